alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
- ALU operand/result datapath that answers the ALU control FSM's strobes.
- Latches operand A on ALUin0 and operand B on ALUin1 from the shared register bus.
- Computes and latches the result and flags on ALUoutlatch, then drives the result onto the bus while ALUoutEN is high.
- Sits between the general-register bus and the ALU control FSM; opcode comes from instruction[15:12].

Parameters:
- DATA_W, 16, datapath and bus width.
- OPC_W, 4, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- opcode  input  OPC_W  instruction[15:12].
- bus_in  input  DATA_W  register bus value, driven by the selected general register.
- ALUin0  input  1  latch strobe for operand A.
- ALUin1  input  1  latch strobe for operand B.
- ALUoutlatch  input  1  compute and latch result and flags.
- ALUoutEN  input  1  drive result onto the bus.
- bus_out  output  DATA_W  result when ALUoutEN=1, else 0.
- bus_oe  output  1  equals ALUoutEN.
- flag_z  output  1  result zero.
- flag_c  output  1  carry/borrow/shift-out.
- flag_n  output  1  result[DATA_W-1].
- flag_v  output  1  signed overflow.
- op_valid  output  1  opcode in 1000..1110, combinational.
- seq_err  output  1  sticky strobe-order error.

Behaviour:
- Reset: all of the following are 0 on a clk edge with rst=0: A, B, result, every flag and seq_err. Sequence state returns to S_IDLE. Reset mid-operation abandons it with no residue.
- Operand latching:
  - ALUin0=1 at an edge: A <= bus_in.
  - ALUin1=1 at an edge: B <= bus_in.
  - Both strobes in one cycle load the same value into A and B.
- Result latching:
  - ALUoutlatch=1 at an edge: result and flags <= f(A, B, opcode), using the registered A and B (pre-edge values).
  - Result is visible one cycle after the ALUoutlatch edge.
- Bus drive: bus_out and bus_oe are combinational from ALUoutEN and the result register. ALUoutEN may be held any number of cycles; the result is stable throughout.
- Operations (W = DATA_W):
  - 1000 ADD: {c, r} = A + B. v = (A[W-1] == B[W-1]) && (r[W-1] != A[W-1]).
  - 1001 SUB: r = A - B. c = 1 when A < B unsigned (borrow). v = (A[W-1] != B[W-1]) && (r[W-1] != A[W-1]).
  - 1010 NOT: r = ~A.
  - 1011 AND: r = A & B.
  - 1100 OR: r = A | B.
  - 1101 XOR: r = A ^ B.
  - 1110 SHL: r = A << B[3:0]. c = last bit shifted out; c = 0 when the shift amount is 0.
  - c and v are 0 for NOT, AND, OR and XOR. z = (r == 0). n = r[W-1].
  - Any other opcode: ALUoutlatch leaves result and flags unchanged, and op_valid = 0.
- Sequence tracker states: S_IDLE, S_A, S_AB, S_RES.
  - S_IDLE: ALUin0 -> S_A. ALUin1 or ALUoutlatch -> seq_err.
  - S_A: ALUin0 -> S_A (reload allowed). ALUin1 -> S_AB. ALUoutlatch -> seq_err.
  - S_AB: ALUoutlatch -> S_RES. ALUin0 or ALUin1 -> seq_err.
  - S_RES: ALUin0 -> S_A (next instruction). ALUin1 or ALUoutlatch -> seq_err.
  - ALUoutEN is legal in every state (it drives the current result, which is 0 after reset).
  - ALUin0 and ALUin1 in the same cycle always set seq_err.
  - On an error the state still follows the strobes' data effects; the tracker stays in its current state.
  - seq_err is sticky and is cleared only by reset.
- Strobes never stall; the block has no backpressure.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined: the sequence tracker and seq_err behave as described above.
- Undefined: the tracker is not built and seq_err is tied to 0. Data behaviour is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD..OP_SHL (4'b1000..4'b1110);
  - sequence-state encoding S_IDLE..S_RES;
  - DATA_W default.
- One sub-module, alu_core: purely combinational f(A, B, opcode) -> {r, c, v}, reused by a future flags/branch unit. Registers and the tracker stay in alu_datapath.

Test Plan:
- ADD: A=0x7FFF, B=0x0001, opcode 1000, ALUoutlatch then ALUoutEN -> bus_out=0x8000, bus_oe=1, n=1, v=1, c=0, z=0.
- SUB borrow: A=0x0003, B=0x0005, opcode 1001 -> result 0xFFFE, c=1, n=1, v=0.
- SHL: A=0x8001, B=0x0001, opcode 1110 -> result 0x0002, c=1. Then B=0x0000 -> result 0x8001, c=0.
- Invalid opcode 0011 with ALUoutlatch after ADD result 0x1234 -> result stays 0x1234, flags unchanged, op_valid=0.
- Order error (ALU_SEQ_CHECK_EN): ALUoutlatch straight after reset -> seq_err=1. seq_err stays 1 through a following legal sequence. Reset (rst=0) -> seq_err=0.
- Reset mid-op: ALUin0 with 0xAAAA, then rst=0 for one cycle, then ALUoutEN=1 -> bus_out=0x0000. Subsequent ALUin1 in S_IDLE -> seq_err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath slice.
// Holds the opcode constants, the strobe-sequence state encoding, the
// default datapath/opcode widths and a small opcode-range helper.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_OPC_W  = 4;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;
    localparam logic [3:0] OP_SHL = 4'b1110;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t S_IDLE = 2'd0;
    localparam seq_state_t S_A    = 2'd1;
    localparam seq_state_t S_AB   = 2'd2;
    localparam seq_state_t S_RES  = 2'd3;

    // True for the seven implemented opcodes (1000..1110).
    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// Bus/strobe bundle between the ALU control FSM, the register bus and the
// ALU datapath.
//   opcode, bus_in, ALUin0, ALUin1, ALUoutlatch, ALUoutEN : master -> slave
//   bus_out, bus_oe, flag_z/c/n/v, op_valid, seq_err      : slave -> master
// master: control side (FSM / testbench); slave: alu_datapath.
interface alu_datapath_if #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 4
);
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] bus_in;
    logic              ALUin0;
    logic              ALUin1;
    logic              ALUoutlatch;
    logic              ALUoutEN;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              flag_z;
    logic              flag_c;
    logic              flag_n;
    logic              flag_v;
    logic              op_valid;
    logic              seq_err;

    modport master (
        output opcode, bus_in, ALUin0, ALUin1, ALUoutlatch, ALUoutEN,
        input  bus_out, bus_oe, flag_z, flag_c, flag_n, flag_v, op_valid, seq_err
    );

    modport slave (
        input  opcode, bus_in, ALUin0, ALUin1, ALUoutlatch, ALUoutEN,
        output bus_out, bus_oe, flag_z, flag_c, flag_n, flag_v, op_valid, seq_err
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU function f(A, B, opcode) -> {r, c, v}.
// Ports:
//   a, b    : operands (DATA_W)
//   opcode  : operation select (OPC_W)
//   r       : result (DATA_W)
//   c       : carry (ADD), borrow (SUB), last bit shifted out (SHL), else 0
//   v       : signed overflow for ADD/SUB, else 0
// Unimplemented opcodes yield zeros; the caller gates latching on op_valid.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OPC_W  = ALU_OPC_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] r,
    output logic              c,
    output logic              v
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W:0]   shl_s;
    logic [SH_W-1:0]   sh_amt_s;

    // The extra top bit of each wide result is the carry, the borrow
    // (A < B unsigned) or the last bit shifted out of the word respectively;
    // a zero shift leaves that bit 0.
    assign sh_amt_s = b[SH_W-1:0];
    assign sum_s    = {1'b0, a} + {1'b0, b};
    assign diff_s   = {1'b0, a} - {1'b0, b};
    assign shl_s    = {1'b0, a} << sh_amt_s;

    // Operation select.
    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (opcode)
            OP_ADD: begin
                r = sum_s[DATA_W-1:0];
                c = sum_s[DATA_W];
                v = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                r = diff_s[DATA_W-1:0];
                c = diff_s[DATA_W];
                v = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
            end
            OP_NOT: r = ~a;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                r = shl_s[DATA_W-1:0];
                c = shl_s[DATA_W];
            end
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// ALU operand/result datapath answering the ALU control FSM strobes.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous reset, active-low
//   bus : alu_datapath_if.slave (opcode, bus_in, ALUin0, ALUin1,
//         ALUoutlatch, ALUoutEN in; bus_out, bus_oe, flag_z/c/n/v,
//         op_valid, seq_err out)
// Optional build macro ALU_SEQ_CHECK_EN: when defined, a strobe-order tracker
// drives the sticky seq_err; when undefined seq_err is tied to 0. Data
// behaviour is the same in both builds.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OPC_W  = ALU_OPC_W
) (
    input logic          clk,
    input logic          rst,
    alu_datapath_if.slave bus
);

    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] result_r;
    logic              flag_z_r;
    logic              flag_c_r;
    logic              flag_n_r;
    logic              flag_v_r;

    logic [DATA_W-1:0] core_r_s;
    logic              core_c_s;
    logic              core_v_s;
    logic              op_valid_s;

    alu_core #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_core (
        .a      (a_r),
        .b      (b_r),
        .opcode (bus.opcode),
        .r      (core_r_s),
        .c      (core_c_s),
        .v      (core_v_s)
    );

    assign op_valid_s = op_is_valid(bus.opcode);

    // Operand latches and result/flag register; invalid opcodes hold the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_v_r <= 1'b0;
        end else begin
            if (bus.ALUin0) begin
                a_r <= bus.bus_in;
            end
            if (bus.ALUin1) begin
                b_r <= bus.bus_in;
            end
            if (bus.ALUoutlatch && op_valid_s) begin
                result_r <= core_r_s;
                flag_z_r <= (core_r_s == '0);
                flag_c_r <= core_c_s;
                flag_n_r <= core_r_s[DATA_W-1];
                flag_v_r <= core_v_s;
            end
        end
    end

    assign bus.bus_out  = bus.ALUoutEN ? result_r : '0;
    assign bus.bus_oe   = bus.ALUoutEN;
    assign bus.flag_z   = flag_z_r;
    assign bus.flag_c   = flag_c_r;
    assign bus.flag_n   = flag_n_r;
    assign bus.flag_v   = flag_v_r;
    assign bus.op_valid = op_valid_s;

`ifdef ALU_SEQ_CHECK_EN
    seq_state_t state_r;
    seq_state_t state_nxt_s;
    logic       seq_err_r;
    logic       err_s;

    // Strobe-order tracker: an illegal strobe flags an error and holds the state.
    always_comb begin
        state_nxt_s = state_r;
        err_s       = 1'b0;
        if (bus.ALUin0 && bus.ALUin1) begin
            err_s = 1'b1;
        end else begin
            case (state_r)
                S_IDLE, S_RES: begin
                    if (bus.ALUin1 || bus.ALUoutlatch) begin
                        err_s = 1'b1;
                    end else if (bus.ALUin0) begin
                        state_nxt_s = S_A;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                S_A: begin
                    if (bus.ALUoutlatch) begin
                        err_s = 1'b1;
                    end else if (bus.ALUin1) begin
                        state_nxt_s = S_AB;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                S_AB: begin
                    if (bus.ALUin0 || bus.ALUin1) begin
                        err_s = 1'b1;
                    end else if (bus.ALUoutlatch) begin
                        state_nxt_s = S_RES;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // Tracker state and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            seq_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (err_s) begin
                seq_err_r <= 1'b1;
            end
        end
    end

    assign bus.seq_err = seq_err_r;
`else
    assign bus.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: table of operations plus hand-written
// corner sequences, with expected results queued at the latch strobe and
// compared when the result is driven onto the bus.
module tb_alu_datapath;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 4;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];
    vec_t vecs[15];

    alu_datapath_if #(.DATA_W(DATA_W), .OPC_W(OPC_W)) bus_if ();

    alu_datapath #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic load(input logic in0, input logic in1, input logic [15:0] d);
        bus_if.ALUin0 = in0;
        bus_if.ALUin1 = in1;
        bus_if.bus_in = d;
        tick();
        bus_if.ALUin0 = 1'b0;
        bus_if.ALUin1 = 1'b0;
    endtask

    task automatic latch(input logic [3:0] op, input exp_t e);
        bus_if.opcode      = op;
        bus_if.ALUoutlatch = 1'b1;
        sb_q.push_back(e);
        tick();
        bus_if.ALUoutlatch = 1'b0;
    endtask

    // Drive the result onto the bus and compare it against the oldest expectation.
    task automatic drive_and_check(input string name);
        exp_t e;
        bus_if.ALUoutEN = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check({name, ".bus_out"}, 32'(bus_if.bus_out), 32'(e.r));
            check({name, ".bus_oe"},  32'(bus_if.bus_oe),  32'd1);
            check({name, ".c"},       32'(bus_if.flag_c),  32'(e.c));
            check({name, ".v"},       32'(bus_if.flag_v),  32'(e.v));
            check({name, ".z"},       32'(bus_if.flag_z),  32'(e.z));
            check({name, ".n"},       32'(bus_if.flag_n),  32'(e.n));
        end
        bus_if.ALUoutEN = 1'b0;
        #1;
        check({name, ".bus_idle"}, 32'(bus_if.bus_out), 32'd0);
        check({name, ".oe_idle"},  32'(bus_if.bus_oe),  32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst                = 1'b0;
        bus_if.opcode      = 4'b0000;
        bus_if.bus_in      = 16'h0000;
        bus_if.ALUin0      = 1'b0;
        bus_if.ALUin1      = 1'b0;
        bus_if.ALUoutlatch = 1'b0;
        bus_if.ALUoutEN    = 1'b0;

        //           op       A         B         r         c     v     z     n
        vecs[0]  = '{4'b1000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b1001, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{4'b1001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b1001, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'b1010, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'b1011, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1100, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'b1101, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'b1110, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b1110, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{4'b1110, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{4'b1110, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'b1110, 16'h00F0, 16'hFFF4, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        tick();
        tick();
        rst = 1'b1;
        check("rst.z",       32'(bus_if.flag_z),  32'd0);
        check("rst.c",       32'(bus_if.flag_c),  32'd0);
        check("rst.n",       32'(bus_if.flag_n),  32'd0);
        check("rst.v",       32'(bus_if.flag_v),  32'd0);
        check("rst.seq_err", 32'(bus_if.seq_err), 32'd0);
        bus_if.ALUoutEN = 1'b1;
        #1;
        check("rst.bus_out", 32'(bus_if.bus_out), 32'd0);
        check("rst.bus_oe",  32'(bus_if.bus_oe),  32'd1);
        bus_if.ALUoutEN = 1'b0;

        // Table of legal A, B, latch, drive sequences.
        for (int i = 0; i < 15; i++) begin
            load(1'b1, 1'b0, vecs[i].a);
            load(1'b0, 1'b1, vecs[i].b);
            bus_if.opcode = vecs[i].op;
            #1;
            check($sformatf("vec%0d.op_valid", i), 32'(bus_if.op_valid), 32'd1);
            latch(vecs[i].op, '{vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
            drive_and_check($sformatf("vec%0d", i));
        end
        check("table.seq_err", 32'(bus_if.seq_err), 32'd0);

        // Invalid opcode leaves result and flags untouched; result stable while driven.
        load(1'b1, 1'b0, 16'h1200);
        load(1'b0, 1'b1, 16'h0034);
        latch(4'b1000, '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_and_check("add1234");
        bus_if.opcode = 4'b0011;
        #1;
        check("op0011.op_valid", 32'(bus_if.op_valid), 32'd0);
        bus_if.opcode = 4'b1111;
        #1;
        check("op1111.op_valid", 32'(bus_if.op_valid), 32'd0);
        bus_if.opcode = 4'b0111;
        #1;
        check("op0111.op_valid", 32'(bus_if.op_valid), 32'd0);
        latch(4'b0011, '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_and_check("invalid_op");
        check("invalid_op.seq_err", 32'(bus_if.seq_err), 32'(SEQ_ON));
        bus_if.ALUoutEN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold%0d.bus_out", k), 32'(bus_if.bus_out), 32'h1234);
        end
        bus_if.ALUoutEN = 1'b0;

        // Latch straight after reset: order error, sticky through a legal sequence.
        do_reset();
        check("rst2.seq_err", 32'(bus_if.seq_err), 32'd0);
        latch(4'b1000, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        drive_and_check("early_latch");
        check("early_latch.seq_err", 32'(bus_if.seq_err), 32'(SEQ_ON));
        load(1'b1, 1'b0, 16'h0002);
        load(1'b0, 1'b1, 16'h0003);
        latch(4'b1000, '{16'h0005, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_and_check("after_err");
        check("sticky.seq_err", 32'(bus_if.seq_err), 32'(SEQ_ON));
        do_reset();
        check("rst3.seq_err", 32'(bus_if.seq_err), 32'd0);

        // Reset mid-operation leaves no residue in A or the result.
        load(1'b1, 1'b0, 16'hAAAA);
        do_reset();
        bus_if.ALUoutEN = 1'b1;
        #1;
        check("midrst.bus_out", 32'(bus_if.bus_out), 32'd0);
        bus_if.ALUoutEN = 1'b0;
        load(1'b0, 1'b1, 16'h0001);
        check("midrst.seq_err", 32'(bus_if.seq_err), 32'(SEQ_ON));
        latch(4'b1000, '{16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_and_check("midrst_add");

        // Both operand strobes in one cycle load the same value.
        do_reset();
        load(1'b1, 1'b1, 16'h0005);
        check("both.seq_err", 32'(bus_if.seq_err), 32'(SEQ_ON));
        latch(4'b1000, '{16'h000A, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_and_check("both_add");

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
